// File: rtl/dog_extrema_detector_if.sv
// Keypoint handshake bundle between the DoG extrema detector (master) and
// the keypoint/descriptor stage (slave).
interface dog_extrema_detector_if #(
    parameter int COORD_WIDTH = 6
) ();
    logic                   kp_valid;
    logic                   kp_ready;
    logic [COORD_WIDTH-1:0] kp_x;
    logic [COORD_WIDTH-1:0] kp_y;
    logic                   kp_is_max;

    modport master (
        output kp_valid,
        output kp_x,
        output kp_y,
        output kp_is_max,
        input  kp_ready
    );

    modport slave (
        input  kp_valid,
        input  kp_x,
        input  kp_y,
        input  kp_is_max,
        output kp_ready
    );
endinterface

// File: rtl/dog_extrema_detector.sv
// Scans the interior of the middle DoG layer, compares each pixel with its 26
// neighbours across three layers and emits strict, high-contrast extrema.
module dog_extrema_detector #(
    parameter int DIMENSION   = 64,
    parameter int THRESHOLD   = 8,
    parameter int COORD_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    dog_ready,
    output logic [11:0]             address,
    input  logic signed [8:0]       lower_pix,
    input  logic signed [8:0]       middle_pix,
    input  logic signed [8:0]       upper_pix,
    dog_extrema_detector_if.master  kp_if,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             kp_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_COMPARE = 3'd2,
        S_EMIT    = 3'd3,
        S_ADVANCE = 3'd4
    } state_t;

    localparam logic [COORD_WIDTH-1:0] C_ONE  = COORD_WIDTH'(1);
    localparam logic [COORD_WIDTH-1:0] C_LAST = COORD_WIDTH'(DIMENSION - 2);

    state_t                  r_state;
    logic                    r_prev_ready;
    logic [COORD_WIDTH-1:0]  r_x;
    logic [COORD_WIDTH-1:0]  r_y;
    logic [3:0]              r_counter;
    logic [11:0]             r_address;
    logic signed [8:0]       r_lo  [0:8];
    logic signed [8:0]       r_mid [0:8];
    logic signed [8:0]       r_up  [0:8];
    logic                    r_kp_valid;
    logic [COORD_WIDTH-1:0]  r_kp_x;
    logic [COORD_WIDTH-1:0]  r_kp_y;
    logic                    r_kp_is_max;
    logic                    r_busy;
    logic                    r_done;
    logic [15:0]             r_kp_count;

    logic signed [8:0]       w_centre;
    logic signed [9:0]       w_centre_ext;
    logic [9:0]              w_abs;
    logic                    w_contrast;
    logic                    w_is_max;
    logic                    w_is_min;
    logic [COORD_WIDTH-1:0]  w_next_x;
    logic [COORD_WIDTH-1:0]  w_next_y;

    // Window index k walks the 3x3 neighbourhood row-major, k=4 being the centre.
    function automatic logic [11:0] window_addr(input logic [COORD_WIDTH-1:0] cx,
                                                input logic [COORD_WIDTH-1:0] cy,
                                                input logic [3:0]             k);
        int row;
        int col;
        row = int'(cy) + int'(k) / 32'sd3 - 32'sd1;
        col = int'(cx) + int'(k) % 32'sd3 - 32'sd1;
        return 12'(row * DIMENSION + col);
    endfunction

    assign w_centre     = r_mid[4];
    assign w_centre_ext = {w_centre[8], w_centre};
    assign w_abs        = w_centre_ext[9] ? 10'(-w_centre_ext) : 10'(w_centre_ext);
    assign w_contrast   = (w_abs >= 10'(THRESHOLD));

    // Strict extremum test: any tie with a neighbour disqualifies the centre.
    always_comb begin
        w_is_max = 1'b1;
        w_is_min = 1'b1;
        for (int k = 0; k < 9; k++) begin
            w_is_max = w_is_max & (w_centre > r_lo[k]) & (w_centre > r_up[k])
                     & ((k == 32'sd4) | (w_centre > r_mid[k]));
            w_is_min = w_is_min & (w_centre < r_lo[k]) & (w_centre < r_up[k])
                     & ((k == 32'sd4) | (w_centre < r_mid[k]));
        end
    end

    // Raster step: x inner, y outer, both restricted to the interior.
    always_comb begin
        w_next_x = r_x;
        w_next_y = r_y;
        if (r_x < C_LAST) begin
            w_next_x = r_x + C_ONE;
        end else begin
            w_next_x = C_ONE;
            w_next_y = r_y + C_ONE;
        end
    end

    // Scan controller, sample bank and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_prev_ready <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_counter    <= 4'd0;
            r_address    <= 12'd0;
            r_kp_valid   <= 1'b0;
            r_kp_x       <= '0;
            r_kp_y       <= '0;
            r_kp_is_max  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_kp_count   <= 16'd0;
            for (int k = 0; k < 9; k++) begin
                r_lo[k]  <= 9'sd0;
                r_mid[k] <= 9'sd0;
                r_up[k]  <= 9'sd0;
            end
        end else begin
            r_prev_ready <= dog_ready;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dog_ready && !r_prev_ready) begin
                        r_state    <= S_FETCH;
                        r_busy     <= 1'b1;
                        r_kp_count <= 16'd0;
                        r_x        <= C_ONE;
                        r_y        <= C_ONE;
                        r_counter  <= 4'd0;
                        r_address  <= window_addr(C_ONE, C_ONE, 4'd0);
                    end
                end
                S_FETCH: begin
                    if (r_counter < 4'd8) begin
                        r_address <= window_addr(r_x, r_y, r_counter + 4'd1);
                    end
                    // Read data trails its address by two cycles.
                    if (r_counter >= 4'd2) begin
                        r_lo[r_counter - 4'd2]  <= lower_pix;
                        r_mid[r_counter - 4'd2] <= middle_pix;
                        r_up[r_counter - 4'd2]  <= upper_pix;
                    end
                    if (r_counter == 4'd10) begin
                        r_state <= S_COMPARE;
                    end else begin
                        r_counter <= r_counter + 4'd1;
                    end
                end
                S_COMPARE: begin
                    if ((w_is_max || w_is_min) && w_contrast) begin
                        r_kp_x      <= r_x;
                        r_kp_y      <= r_y;
                        r_kp_is_max <= w_is_max;
                        r_kp_valid  <= 1'b1;
                        r_state     <= S_EMIT;
                    end else begin
                        r_state <= S_ADVANCE;
                    end
                end
                S_EMIT: begin
                    if (kp_if.kp_ready) begin
                        r_kp_valid <= 1'b0;
                        r_kp_count <= (r_kp_count != 16'hFFFF) ? r_kp_count + 16'd1 : r_kp_count;
                        r_state    <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if ((r_x == C_LAST) && (r_y == C_LAST)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_x       <= w_next_x;
                        r_y       <= w_next_y;
                        r_counter <= 4'd0;
                        r_address <= window_addr(w_next_x, w_next_y, 4'd0);
                        r_state   <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign address         = r_address;
    assign busy            = r_busy;
    assign done            = r_done;
    assign kp_count        = r_kp_count;
    assign kp_if.kp_valid  = r_kp_valid;
    assign kp_if.kp_x      = r_kp_x;
    assign kp_if.kp_y      = r_kp_y;
    assign kp_if.kp_is_max = r_kp_is_max;

endmodule

// File: tb/tb_dog_extrema_detector.sv
// Self-checking bench for dog_extrema_detector on an 8x8 image: directed spikes,
// backpressure, reset abort and randomized layers against a 26-neighbour model.
module tb_dog_extrema_detector;

    localparam int D    = 8;
    localparam int THR  = 8;
    localparam int CW   = 6;
    localparam int NPIX = D * D;
    localparam int BASE = (D - 2) * (D - 2) * 13;

    typedef struct {
        int x;
        int y;
        int mx;
    } kp_t;

    logic              clk = 1'b0;
    logic              rst_in;
    logic              dog_ready;
    logic [11:0]       address;
    logic signed [8:0] lower_pix, middle_pix, upper_pix;
    logic signed [8:0] p1_lo, p1_mid, p1_up;
    logic              busy, done;
    logic [15:0]       kp_count;

    int  lo_m [NPIX];
    int  mid_m[NPIX];
    int  up_m [NPIX];
    kp_t exp_q[$];
    kp_t got_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    dog_extrema_detector_if #(.COORD_WIDTH(CW)) kp_if ();

    dog_extrema_detector #(
        .DIMENSION  (D),
        .THRESHOLD  (THR),
        .COORD_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .dog_ready (dog_ready),
        .address   (address),
        .lower_pix (lower_pix),
        .middle_pix(middle_pix),
        .upper_pix (upper_pix),
        .kp_if     (kp_if),
        .busy      (busy),
        .done      (done),
        .kp_count  (kp_count)
    );

    always #5 clk = ~clk;

    // Three BRAMs with two-cycle read latency.
    always @(posedge clk) begin
        p1_lo      <= (int'(address) < NPIX) ? 9'(lo_m[int'(address)])  : 9'sd0;
        p1_mid     <= (int'(address) < NPIX) ? 9'(mid_m[int'(address)]) : 9'sd0;
        p1_up      <= (int'(address) < NPIX) ? 9'(up_m[int'(address)])  : 9'sd0;
        lower_pix  <= p1_lo;
        middle_pix <= p1_mid;
        upper_pix  <= p1_up;
    end

    function automatic int pix(input int layer, input int x, input int y);
        case (layer)
            0:       return lo_m[y * D + x];
            1:       return mid_m[y * D + x];
            default: return up_m[y * D + x];
        endcase
    endfunction

    // Reference: every interior pixel against its 26 neighbours, raster order.
    task automatic build_expected();
        int c, v, gt, lt, mag;
        exp_q.delete();
        for (int y = 1; y <= D - 2; y++) begin
            for (int x = 1; x <= D - 2; x++) begin
                c  = pix(1, x, y);
                gt = 1;
                lt = 1;
                for (int l = 0; l < 3; l++)
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++) begin
                            if (l == 1 && dy == 0 && dx == 0) continue;
                            v = pix(l, x + dx, y + dy);
                            if (c <= v) gt = 0;
                            if (c >= v) lt = 0;
                        end
                mag = (c < 0) ? -c : c;
                if ((gt == 1 || lt == 1) && mag >= THR) exp_q.push_back(kp_t'{x, y, gt});
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NPIX; i++) begin
            lo_m[i] = 0; mid_m[i] = 0; up_m[i] = 0;
        end
    endtask

    // Start a scan and collect transfers until done; cyc = negedges after the start edge.
    task automatic run_scan(input int ready_mode, input int toggle_at,
                            output int cyc, output int n_match);
        got_q.delete();
        cyc = -1;
        @(negedge clk);
        dog_ready = 1'b1;
        kp_if.kp_ready = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (i == 2) dog_ready = 1'b0;
            if (toggle_at > 0 && i == toggle_at) dog_ready = 1'b1;
            if (toggle_at > 0 && i == toggle_at + 3) dog_ready = 1'b0;
            kp_if.kp_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (kp_if.kp_valid && kp_if.kp_ready)
                got_q.push_back(kp_t'{int'(kp_if.kp_x), int'(kp_if.kp_y), int'(kp_if.kp_is_max)});
            if (done) begin
                cyc = i;
                break;
            end
        end
        n_match = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i].x == exp_q[i].x && got_q[i].y == exp_q[i].y && got_q[i].mx == exp_q[i].mx)
                n_match++;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; dog_ready = 1'b0; kp_if.kp_ready = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({address, busy, done, kp_count, kp_if.kp_valid, kp_if.kp_x, kp_if.kp_y, kp_if.kp_is_max} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got addr=%0d busy=%0b done=%0b cnt=%0d valid=%0b, required all 0",
                     address, busy, done, kp_count, kp_if.kp_valid);
        end
        rst_in = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_start: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_zero();
        int cyc, nm;
        clear_mem();
        run_scan(0, 0, cyc, nm);
        n_vec++;
        if (cyc !== BASE) begin n_err++; $display("FAIL zero_cycles: got %0d required %0d", cyc, BASE); end
        n_vec++;
        if (got_q.size() !== 0) begin n_err++; $display("FAIL zero_kps: got %0d required 0", got_q.size()); end
        n_vec++;
        if (kp_count !== 16'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL zero_count: cnt=%0d busy=%0b required 0/0", kp_count, busy);
        end
    endtask

    task automatic test_spike(input string name, input int sx, input int sy, input int val,
                              input bit tie, input int exp_n, input int exp_max);
        int cyc, nm;
        clear_mem();
        mid_m[sy * D + sx] = val;
        if (tie) up_m[sy * D + sx] = val;
        run_scan(0, 0, cyc, nm);
        n_vec++;
        if (got_q.size() !== exp_n) begin
            n_err++; $display("FAIL %s_num: got %0d keypoints required %0d", name, got_q.size(), exp_n);
        end else if (exp_n == 1) begin
            n_vec++;
            if (got_q[0].x !== sx || got_q[0].y !== sy || got_q[0].mx !== exp_max) begin
                n_err++;
                $display("FAIL %s_kp: got (%0d,%0d,max=%0d) required (%0d,%0d,max=%0d)",
                         name, got_q[0].x, got_q[0].y, got_q[0].mx, sx, sy, exp_max);
            end
        end
        n_vec++;
        if (kp_count !== 16'(exp_n) || cyc !== BASE + exp_n) begin
            n_err++;
            $display("FAIL %s_count: got cnt=%0d cyc=%0d required cnt=%0d cyc=%0d",
                     name, kp_count, cyc, exp_n, BASE + exp_n);
        end
    endtask

    task automatic test_backpressure();
        int stall = 0, xfer = 0, cyc = -1;
        clear_mem();
        mid_m[3 * D + 5] = 50;
        @(negedge clk);
        dog_ready = 1'b1;
        kp_if.kp_ready = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (i == 2) dog_ready = 1'b0;
            if (kp_if.kp_valid) begin
                stall++;
                n_vec++;
                if (kp_if.kp_x !== CW'(5) || kp_if.kp_y !== CW'(3) || kp_if.kp_is_max !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_stable: cycle %0d got (%0d,%0d,%0b) required (5,3,1)",
                             stall, kp_if.kp_x, kp_if.kp_y, kp_if.kp_is_max);
                end
                if (stall == 21) kp_if.kp_ready = 1'b1;
                if (kp_if.kp_ready) xfer++;
            end
            if (done) begin cyc = i; break; end
        end
        n_vec++;
        if (stall !== 21 || xfer !== 1) begin
            n_err++; $display("FAIL bp_xfer: valid cycles=%0d xfers=%0d required 21/1", stall, xfer);
        end
        n_vec++;
        if (kp_count !== 16'd1 || cyc !== BASE + 21) begin
            n_err++; $display("FAIL bp_done: cnt=%0d cyc=%0d required 1/%0d", kp_count, cyc, BASE + 21);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, nm, n_done = 0, n_busy = 0;
        clear_mem();
        mid_m[1 * D + 1] = 50;
        build_expected();
        @(negedge clk);
        dog_ready = 1'b1;
        kp_if.kp_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 2) dog_ready = 1'b0;
            if (i == 19) begin
                n_vec++;
                if (kp_count !== 16'd1 || busy !== 1'b1) begin
                    n_err++; $display("FAIL pre_reset: cnt=%0d busy=%0b required 1/1", kp_count, busy);
                end
                rst_in = 1'b1;
            end
            if (i == 20) begin
                n_vec++;
                if ({address, busy, done, kp_count, kp_if.kp_valid, kp_if.kp_x, kp_if.kp_y, kp_if.kp_is_max} !== '0) begin
                    n_err++;
                    $display("FAIL mid_reset: addr=%0d busy=%0b cnt=%0d valid=%0b required all 0",
                             address, busy, kp_count, kp_if.kp_valid);
                end
                rst_in = 1'b0;
            end
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        n_vec++;
        if (n_done !== 0 || n_busy !== 0) begin
            n_err++; $display("FAIL abort_quiet: done=%0d busy=%0d required 0/0", n_done, n_busy);
        end
        // Restart; the extra dog_ready edge at cycle 100 must not disturb the scan.
        run_scan(0, 100, cyc, nm);
        n_vec++;
        if (cyc !== BASE + 1 || got_q.size() !== 1 || nm !== 1 || kp_count !== 16'd1) begin
            n_err++;
            $display("FAIL restart: cyc=%0d kps=%0d match=%0d cnt=%0d required %0d/1/1/1",
                     cyc, got_q.size(), nm, kp_count, BASE + 1);
        end
    endtask

    task automatic test_random();
        int cyc, nm, mode;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NPIX; i++) begin
                if (t % 2 == 0) begin
                    lo_m[i]  = int'($urandom_range(0, 80)) - 40;
                    mid_m[i] = int'($urandom_range(0, 80)) - 40;
                    up_m[i]  = int'($urandom_range(0, 80)) - 40;
                end else begin
                    lo_m[i]  = int'($urandom_range(0, 511)) - 256;
                    mid_m[i] = int'($urandom_range(0, 511)) - 256;
                    up_m[i]  = int'($urandom_range(0, 511)) - 256;
                end
            end
            build_expected();
            mode = (t >= 3) ? 1 : 0;
            run_scan(mode, 0, cyc, nm);
            n_vec++;
            if (cyc < 0 || got_q.size() !== exp_q.size() || nm !== exp_q.size()) begin
                n_err++;
                $display("FAIL rand%0d_kps: got %0d kps (%0d matching) cyc=%0d required %0d",
                         t, got_q.size(), nm, cyc, exp_q.size());
            end
            n_vec++;
            if (kp_count !== 16'(exp_q.size())) begin
                n_err++; $display("FAIL rand%0d_count: got %0d required %0d", t, kp_count, exp_q.size());
            end
            if (mode == 0) begin
                n_vec++;
                if (cyc !== BASE + exp_q.size()) begin
                    n_err++;
                    $display("FAIL rand%0d_cycles: got %0d required %0d", t, cyc, BASE + exp_q.size());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_spike("max50",   5, 3,   50, 1'b0, 1, 1);
        test_spike("low5",    5, 3,    5, 1'b0, 0, 0);
        test_spike("min40",   5, 3,  -40, 1'b0, 1, 0);
        test_spike("min256",  2, 2, -256, 1'b0, 1, 0);
        test_spike("tie",     5, 3,   50, 1'b1, 0, 0);
        test_spike("border",  0, 3,   50, 1'b0, 0, 0);
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dog_extrema_detector.md
Name: dog_extrema_detector

Overview:
- Downstream consumer of the difference-of-Gaussian (DoG) stage.
- Once three adjacent DoG layers (lower, middle, upper) of one octave sit in BRAM, scans every interior pixel of the middle layer and compares it against its 26 neighbours in the 3x3x3 cube.
- Emits coordinates of strict local maxima/minima whose magnitude passes a contrast threshold, over a valid/ready handshake, to the keypoint/descriptor stage.

Parameters:
- DIMENSION, 64, square image side in pixels; DIMENSION >= 3 and DIMENSION*DIMENSION <= 4096.
- THRESHOLD, 8, minimum |centre| (unsigned, 0..255) for a keypoint.
- COORD_WIDTH, 6, width of kp_x/kp_y; must satisfy 2**COORD_WIDTH >= DIMENSION.

Ports:
- clk  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- dog_ready  in  1  level; DoG layers written; a rising edge starts a scan.
- address  out  12  read address, shared by all three DoG BRAMs.
- lower_pix  in  9  signed DoG sample, lower layer, 2-cycle read latency.
- middle_pix  in  9  signed DoG sample, middle layer, 2-cycle read latency.
- upper_pix  in  9  signed DoG sample, upper layer, 2-cycle read latency.
- kp_valid  out  1  keypoint coordinates valid.
- kp_ready  in  1  consumer accepts keypoint.
- kp_x  out  COORD_WIDTH  keypoint column.
- kp_y  out  COORD_WIDTH  keypoint row.
- kp_is_max  out  1  1 = maximum, 0 = minimum.
- busy  out  1  high from start until scan completes.
- done  out  1  one-cycle pulse at end of scan.
- kp_count  out  16  keypoints emitted in current/last scan; saturates at 65535.

Behaviour:
- Reset: all outputs 0; state IDLE; internal registers (x, y, counter, sample bank) cleared. Reset mid-scan aborts immediately; no done pulse. A scan starts only on a dog_ready rising edge after reset deasserts.
- dog_ready edge detect: registered previous value; start when dog_ready & ~prev in IDLE. Edges while busy are ignored.
- States: IDLE, FETCH, COMPARE, EMIT, ADVANCE.
- IDLE -> FETCH on start: busy<=1, kp_count<=0, x<=1, y<=1, counter<=0.
- Scan order: y outer, x inner, both 1..DIMENSION-2. Border pixels are never candidates.
- FETCH lasts 11 cycles, counter 0..10.
  - Counters 0..8: address = (y+dy)*DIMENSION + (x+dx), with (dy,dx) walked row-major over -1..1, index k = counter.
  - After counter 8, address holds its last value.
  - Counters 2..10: latch lower/middle/upper samples for index k = counter-2 into a 27-entry signed bank.
  - Exits to COMPARE after counter 10.
- COMPARE, one cycle:
  - centre = middle sample at k=4.
  - is_max: centre strictly greater (signed) than all 26 others.
  - is_min: centre strictly less than all 26 others.
  - Any equality means not an extremum.
  - Contrast: |centre| >= THRESHOLD. Compute |centre| in 10 bits so -256 is handled.
  - If (is_max | is_min) & contrast: load kp_x=x, kp_y=y, kp_is_max=is_max; assert kp_valid; go to EMIT. Otherwise go to ADVANCE.
- EMIT: hold kp_valid, kp_x, kp_y, kp_is_max stable until kp_ready is high on a clock edge. On that edge: kp_valid<=0, kp_count increments (saturating), go to ADVANCE. kp_ready with kp_valid low has no effect.
- ADVANCE, one cycle:
  - If x < DIMENSION-2: x+1.
  - Else x<=1, y+1.
  - If the last pixel (DIMENSION-2, DIMENSION-2) is finished: busy<=0, done<=1 for one cycle, go to IDLE.
  - Otherwise return to FETCH with counter<=0.
- Throughput: 13 cycles per non-keypoint pixel (FETCH 11, COMPARE 1, ADVANCE 1); a keypoint adds 1 cycle plus any backpressure stall.
- DIMENSION=3: exactly one candidate, (1,1).
- kp_count holds its final value in IDLE until the next start.

Test Plan:
- DIMENSION=8, all three layers all-zero, pulse dog_ready -> no kp_valid; done after 36*13=468 cycles following start; kp_count=0.
- Middle layer value 50 at (x=5,y=3), all else 0, THRESHOLD=8 -> exactly one kp_valid with kp_x=5, kp_y=3, kp_is_max=1; kp_count=1.
- Same spike with value 5 -> no keypoint (contrast fail). Value -40 -> one keypoint at (5,3) with kp_is_max=0.
- Spike 50 at (5,3) and upper layer also 50 at (5,3) -> no keypoint (tie). Spike 50 at border (0,3) -> no keypoint.
- Keypoint present, kp_ready held low 20 cycles -> kp_valid and coordinates stable for all 20 cycles; one transfer when kp_ready rises; scan resumes.
- Assert rst_in for one cycle mid-FETCH -> next cycle all outputs 0 and no done pulse. A later dog_ready edge restarts a full scan from (1,1). A dog_ready edge while busy is ignored.
